// File: rtl/lsu_pkg.sv
// Shared types, widths and request checking for the load/store unit.
// LSU_SUBWORD_EN adds byte/half accesses and the RMW_WR state.
package lsu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int WIDX_W = 6;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

`ifdef LSU_SUBWORD_EN
  typedef enum logic [2:0] {IDLE, RD, LD_DONE, RMW_WR, ST_WR} state_e;
`else
  typedef enum logic [2:0] {IDLE, RD, LD_DONE, ST_WR} state_e;
`endif

  // Reserved size and misaligned accesses are rejected before touching memory.
  function automatic logic reqIsErr(input logic [1:0] size, input logic [1:0] addrLo);
    logic err;
    err = 1'b0;
    case (size)
      SZ_WORD: err = (addrLo != 2'b00);
`ifdef LSU_SUBWORD_EN
      SZ_HALF: err = addrLo[0];
      SZ_BYTE: err = 1'b0;
`endif
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus word-memory port of the load/store unit.
interface lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  localparam int WIDX_W = ADDR_W - 2;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic [WIDX_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_we2;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_data, resp_err, mem_address, mem_write_data, mem_we2
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_data, resp_err, mem_address, mem_write_data, mem_we2
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction for loads and lane merge for stores.
// Without LSU_SUBWORD_EN only whole words pass through.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        addrLo_i,
  input  logic              sgnExt_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] loadData_o,
  output logic [DATA_W-1:0] storeData_o
);

`ifdef LSU_SUBWORD_EN
  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane    = rdata_i[{addrLo_i, 3'b000} +: 8];
    halfLane    = rdata_i[{addrLo_i[1], 4'b0000} +: 16];
    loadData_o  = rdata_i;
    storeData_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        loadData_o  = {{24{sgnExt_i & byteLane[7]}}, byteLane};
        storeData_o = rdata_i;
        storeData_o[{addrLo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        loadData_o  = {{16{sgnExt_i & halfLane[15]}}, halfLane};
        storeData_o = rdata_i;
        storeData_o[{addrLo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        loadData_o  = rdata_i;
        storeData_o = wdata_i;
      end
    endcase
  end
`else
  logic unusedLaneCtrl;

  assign unusedLaneCtrl = ^{size_i, addrLo_i, sgnExt_i};
  assign loadData_o     = rdata_i;
  assign storeData_o    = wdata_i;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word memory with 1-cycle reads.
// LSU_SUBWORD_EN enables byte/half loads and read-modify-write stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = lsu_pkg::DATA_W,
  parameter int ADDR_W = lsu_pkg::ADDR_W
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  state_e            state_q;
  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              errPend_q;
  logic              respValid_q;
  logic              respErr_q;
  logic [DATA_W-1:0] respData_q;

  logic              accept;
  logic              reqErr;
  logic              wrState;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] storeData;

  assign bus.req_ready = (state_q == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign reqErr        = reqIsErr(bus.req_size, bus.req_addr[1:0]);

`ifdef LSU_SUBWORD_EN
  assign wrState = (state_q == ST_WR) || (state_q == RMW_WR);
`else
  assign wrState = (state_q == ST_WR);
`endif

  // Gating with reset kills an in-flight write the moment reset falls.
  assign bus.mem_we2        = reset && we_q && wrState;
  assign bus.mem_address    = (state_q == IDLE) ? '0 : addr_q[ADDR_W-1:2];
  assign bus.mem_write_data = wrState ? storeData : '0;

  assign bus.resp_valid = respValid_q;
  assign bus.resp_err   = respErr_q;
  assign bus.resp_data  = respData_q;

  lsu_lane_align u_align (
    .size_i      (size_q),
    .addrLo_i    (addr_q[1:0]),
    .sgnExt_i    (signed_q),
    .rdata_i     (bus.mem_read_data),
    .wdata_i     (wdata_q),
    .loadData_o  (loadData),
    .storeData_o (storeData)
  );

  // Rejected requests stay in IDLE; errPend_q delays their response by one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      errPend_q   <= 1'b0;
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      respData_q  <= '0;
    end else begin
      respValid_q <= 1'b0;
      errPend_q   <= 1'b0;
      if (errPend_q) begin
        respValid_q <= 1'b1;
        respErr_q   <= 1'b1;
        respData_q  <= '0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q     <= bus.req_we;
            signed_q <= bus.req_signed;
            size_q   <= bus.req_size;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            if (reqErr) begin
              errPend_q <= 1'b1;
            end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
              state_q <= ST_WR;
            end else begin
              state_q <= RD;
            end
          end
        end
`ifdef LSU_SUBWORD_EN
        RD: state_q <= we_q ? RMW_WR : LD_DONE;
        RMW_WR: begin
          state_q     <= IDLE;
          respValid_q <= 1'b1;
          respErr_q   <= 1'b0;
          respData_q  <= '0;
        end
`else
        RD: state_q <= LD_DONE;
`endif
        LD_DONE: begin
          state_q     <= IDLE;
          respValid_q <= 1'b1;
          respErr_q   <= 1'b0;
          respData_q  <= loadData;
        end
        ST_WR: begin
          state_q     <= IDLE;
          respValid_q <= 1'b1;
          respErr_q   <= 1'b0;
          respData_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort and back-to-back
// sequences, then random requests scored against a word-array reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

`ifdef LSU_SUBWORD_EN
  localparam bit SubwordEn = 1'b1;
`else
  localparam bit SubwordEn = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expData;
    int          expLat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic memClear;
  logic [31:0] mem [64];
  logic [31:0] rdReg;
  logic [31:0] refMem [64];
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  load_store_unit #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Word memory with a registered read port, as the unit expects.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    end else if (bus.mem_we2) begin
      mem[bus.mem_address] <= bus.mem_write_data;
    end else begin
      rdReg <= mem[bus.mem_address];
    end
  end
  assign bus.mem_read_data = rdReg;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic expErr, input logic [31:0] expData, input int expLat);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.expErr = expErr; v.expData = expData; v.expLat = expLat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: memory as plain words, access as (bytes, lane) arithmetic.
  task automatic refModel(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          output logic expErr, output logic [31:0] expData, output int expLat);
    int unsigned widx, lane, nbytes;
    logic [31:0] word, mask, val;
    widx = addr / 4;
    lane = addr % 4;
    expErr = (size == 2'd3) || (!SubwordEn && size != 2'd2) ||
             (size == 2'd1 && (lane % 2) != 0) || (size == 2'd2 && lane != 0);
    expData = 32'd0;
    expLat = 1;
    if (!expErr) begin
      nbytes = 1 << size;
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      word = refMem[widx];
      if (we) begin
        refMem[widx] = (word & ~(mask << (8 * lane))) | ((wdata & mask) << (8 * lane));
        expLat = (nbytes == 4) ? 1 : 2;
      end else begin
        val = (word >> (8 * lane)) & mask;
        if (sgn && nbytes < 4 && val >= (mask + 32'd1) / 2) val = val | ~mask;
        expData = val;
        expLat = 2;
      end
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [7:0] addr, input logic [31:0] wdata,
                               output logic gotErr, output logic [31:0] gotData, output int lat,
                               output int writes, output logic [5:0] firstAddr, output logic pulseOk);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
    checkOutput("ready before accept", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_signed = 1'($urandom); bus.req_addr = 8'($urandom); bus.req_wdata = $urandom;
    firstAddr = bus.mem_address;
    writes = bus.mem_we2 ? 1 : 0;
    lat = 0; gotErr = 1'b0; gotData = 32'd0; pulseOk = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = k; gotErr = bus.resp_err; gotData = bus.resp_data;
      end else if (bus.mem_we2) begin
        writes++;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      pulseOk = !bus.resp_valid && (bus.resp_data == gotData) && (bus.resp_err == gotErr);
    end
  endtask

  task automatic runAndCheck(input string name, input logic we, input logic [1:0] size, input logic sgn,
                             input logic [7:0] addr, input logic [31:0] wdata,
                             input logic expErr, input logic [31:0] expData, input int expLat);
    logic gotErr, pulseOk;
    logic [31:0] gotData;
    int lat, writes;
    logic [5:0] firstAddr;
    applyStimulus(we, size, sgn, addr, wdata, gotErr, gotData, lat, writes, firstAddr, pulseOk);
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " err"}, {31'd0, gotErr}, {31'd0, expErr});
    checkOutput({name, " data"}, gotData, expData);
    checkOutput({name, " writes"}, writes, (!expErr && we) ? 32'd1 : 32'd0);
    checkOutput({name, " addr"}, {26'd0, firstAddr}, {26'd0, expErr ? 6'd0 : addr[7:2]});
    checkOutput({name, " pulse"}, {31'd0, pulseOk}, 32'd1);
  endtask

  task automatic modelAndRun(input string name, input logic we, input logic [1:0] size,
                             input logic sgn, input logic [7:0] addr, input logic [31:0] wdata);
    logic expErr;
    logic [31:0] expData;
    int expLat;
    refModel(we, size, sgn, addr, wdata, expErr, expData, expLat);
    runAndCheck(name, we, size, sgn, addr, wdata, expErr, expData, expLat);
  endtask

  // Reset falls while a write is in flight; the write and its response must vanish.
  task automatic abortWrite(input string name, input logic [1:0] size, input logic [7:0] addr,
                            input int writeNeg);
    logic [31:0] oldWord;
    int respSeen;
    oldWord = refMem[addr[7:2]];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = size;
    bus.req_signed = 1'b0; bus.req_addr = addr; bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 1; i < writeNeg; i++) @(negedge clk);
    checkOutput({name, " we2 before"}, {31'd0, bus.mem_we2}, 32'd1);
    #1 reset = 1'b0;
    #1 checkOutput({name, " we2 abort"}, {31'd0, bus.mem_we2}, 32'd0);
    respSeen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 if (bus.resp_valid) respSeen++;
    end
    checkOutput({name, " no resp"}, respSeen, 32'd0);
    checkOutput({name, " mem kept"}, mem[addr[7:2]], oldWord);
    #1 reset = 1'b1;
    runAndCheck({name, " reload"}, 1'b0, 2'd2, 1'b0, {addr[7:2], 2'b00}, 32'd0, 1'b0, oldWord, 2);
  endtask

  task automatic backToBack();
    logic [7:0]  addrs [3];
    logic        wes [3];
    logic [31:0] wdatas [3];
    logic [31:0] expData [3];
    int          expAt [3];
    logic        eErr;
    int          eLat, pulses, cycles, extra;
    addrs = '{8'h10, 8'h14, 8'h14};
    wes = '{1'b0, 1'b1, 1'b0};
    wdatas = '{32'd0, $urandom, 32'd0};
    for (int i = 0; i < 3; i++) begin
      refModel(wes[i], 2'd2, 1'b0, addrs[i], wdatas[i], eErr, expData[i], eLat);
      expAt[i] = (i == 0 ? 0 : expAt[i-1]) + eLat + 1;
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_we = wes[0]; bus.req_addr = addrs[0]; bus.req_wdata = wdatas[0];
    pulses = 0; cycles = 0;
    while (pulses < 3 && cycles < 30) begin
      @(negedge clk);
      cycles++;
      if (bus.resp_valid) begin
        checkOutput($sformatf("b2b%0d data", pulses), bus.resp_data, expData[pulses]);
        checkOutput($sformatf("b2b%0d cycle", pulses), cycles, expAt[pulses]);
        checkOutput($sformatf("b2b%0d ready", pulses), {31'd0, bus.req_ready}, 32'd1);
        pulses++;
        if (pulses < 3) begin
          bus.req_we = wes[pulses]; bus.req_addr = addrs[pulses]; bus.req_wdata = wdatas[pulses];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) extra++;
    end
    checkOutput("b2b pulses", pulses + extra, 32'd3);
  endtask

  initial begin
    logic dErr;
    logic [31:0] dData;
    int dLat;
    logic [1:0] rSize;
    logic [7:0] rAddr;

    vecs.push_back(mkVec(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1));
    vecs.push_back(mkVec(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2));
    vecs.push_back(mkVec(1'b0, 2'd2, 1'b1, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2));
    vecs.push_back(mkVec(1'b0, 2'd3, 1'b0, 8'h10, 32'h0, 1'b1, 32'h0, 1));
    vecs.push_back(mkVec(1'b0, 2'd2, 1'b0, 8'h12, 32'h0, 1'b1, 32'h0, 1));
    vecs.push_back(mkVec(1'b1, 2'd2, 1'b0, 8'h11, 32'h12345678, 1'b1, 32'h0, 1));
    vecs.push_back(mkVec(1'b1, 2'd3, 1'b0, 8'h14, 32'h12345678, 1'b1, 32'h0, 1));
`ifdef LSU_SUBWORD_EN
    vecs.push_back(mkVec(1'b1, 2'd2, 1'b0, 8'h10, 32'h11223344, 1'b0, 32'h0, 1));
    vecs.push_back(mkVec(1'b1, 2'd0, 1'b0, 8'h12, 32'h000000AA, 1'b0, 32'h0, 2));
    vecs.push_back(mkVec(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 1'b0, 32'h11AA3344, 2));
    vecs.push_back(mkVec(1'b0, 2'd0, 1'b1, 8'h12, 32'h0, 1'b0, 32'hFFFFFFAA, 2));
    vecs.push_back(mkVec(1'b0, 2'd0, 1'b0, 8'h12, 32'h0, 1'b0, 32'h000000AA, 2));
    vecs.push_back(mkVec(1'b1, 2'd2, 1'b0, 8'h10, 32'h80013344, 1'b0, 32'h0, 1));
    vecs.push_back(mkVec(1'b0, 2'd1, 1'b1, 8'h12, 32'h0, 1'b0, 32'hFFFF8001, 2));
    vecs.push_back(mkVec(1'b0, 2'd1, 1'b0, 8'h12, 32'h0, 1'b0, 32'h00008001, 2));
    vecs.push_back(mkVec(1'b0, 2'd1, 1'b0, 8'h13, 32'h0, 1'b1, 32'h0, 1));
    vecs.push_back(mkVec(1'b1, 2'd1, 1'b0, 8'h10, 32'h1234BEEF, 1'b0, 32'h0, 2));
    vecs.push_back(mkVec(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 1'b0, 32'h8001BEEF, 2));
    vecs.push_back(mkVec(1'b0, 2'd0, 1'b1, 8'h11, 32'h0, 1'b0, 32'hFFFFFFBE, 2));
    vecs.push_back(mkVec(1'b0, 2'd0, 1'b0, 8'h13, 32'h0, 1'b0, 32'h00000080, 2));
`else
    vecs.push_back(mkVec(1'b0, 2'd0, 1'b0, 8'h10, 32'h0, 1'b1, 32'h0, 1));
    vecs.push_back(mkVec(1'b1, 2'd1, 1'b0, 8'h10, 32'h0000BEEF, 1'b1, 32'h0, 1));
    vecs.push_back(mkVec(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2));
`endif

    for (int i = 0; i < 64; i++) refMem[i] = 32'd0;
    reset = 1'b0;
    memClear = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 8'd0; bus.req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    memClear = 1'b0;
    @(negedge clk);
    checkOutput("reset ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    checkOutput("reset resp_err", {31'd0, bus.resp_err}, 32'd0);
    checkOutput("reset resp_data", bus.resp_data, 32'd0);
    checkOutput("reset mem_we2", {31'd0, bus.mem_we2}, 32'd0);
    checkOutput("reset mem_address", {26'd0, bus.mem_address}, 32'd0);
    checkOutput("reset mem_write_data", bus.mem_write_data, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;

    $display("[TB] directed vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      refModel(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, dErr, dData, dLat);
      runAndCheck($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                  vecs[i].wdata, vecs[i].expErr, vecs[i].expData, vecs[i].expLat);
    end

    $display("[TB] reset-abort sequences");
    modelAndRun("prep 0x20", 1'b1, 2'd2, 1'b0, 8'h20, 32'h5A5A_A5A5);
    abortWrite("abort ST_WR", 2'd2, 8'h20, 1);
`ifdef LSU_SUBWORD_EN
    abortWrite("abort RMW_WR", 2'd0, 8'h21, 2);
`endif

    $display("[TB] back-to-back sequence");
    backToBack();

    $display("[TB] random requests");
    for (int n = 0; n < 120; n++) begin
      rSize = 2'($urandom_range(0, 3));
      rAddr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) rAddr[1:0] = 2'b00;
      modelAndRun($sformatf("rnd%0d", n), 1'($urandom), rSize, 1'($urandom), rAddr, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
